axi_read_arbiter: RTL and testbench

Two-master AXI4 read-channel arbiter that shares the AR/R channels of one `SimDRAM` channel between two requesters.
- AR requests are accepted round-robin, tagged with the requester index in the ID MSB, and forwarded through a one-entry register slice.
- R beats are routed back by that ID bit.
- Per-master outstanding-burst counters throttle each requester to `MAX_OUTSTANDING`.
- Write channels do not pass through this block.

---
 rtl/axi_read_arbiter_if.sv | 42 ++++
 rtl/axi_read_arbiter.sv | 93 +++++++++
 tb/tb_axi_read_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_if.sv
// AR/R channel bundle between two read masters, the arbiter and one DRAM channel.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface axi_read_arbiter_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 4
);
    localparam int AR_W = ADDR_BITS + 8 + 3 + ID_BITS;

    logic [1:0]           m_ar_valid;
    logic [1:0]           m_ar_ready;
    logic [2*AR_W-1:0]    m_ar_bits;
    logic [1:0]           m_r_valid;
    logic [1:0]           m_r_ready;
    logic [DATA_BITS-1:0] m_r_data;
    logic [ID_BITS-1:0]   m_r_id;
    logic [1:0]           m_r_resp;
    logic                 m_r_last;
    logic                 s_ar_valid;
    logic                 s_ar_ready;
    logic [AR_W:0]        s_ar_bits;
    logic                 s_r_valid;
    logic                 s_r_ready;
    logic [DATA_BITS-1:0] s_r_data;
    logic [ID_BITS:0]     s_r_id;
    logic [1:0]           s_r_resp;
    logic                 s_r_last;

    modport slave (
        input  m_ar_valid, m_ar_bits, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last,
        output s_ar_valid, s_ar_bits, s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last
    );

    modport master (
        output m_ar_valid, m_ar_bits, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last,
        input  s_ar_valid, s_ar_bits, s_r_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin AR arbiter for two read masters sharing one DRAM channel.
// Requester index rides in the ID MSB and steers R beats back.
module axi_read_arbiter #(
    parameter int ADDR_BITS       = 32,
    parameter int DATA_BITS       = 64,
    parameter int ID_BITS         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic              clock,
    input logic              reset,
    axi_read_arbiter_if.slave bus
);
    localparam int AR_W = ADDR_BITS + 8 + 3 + ID_BITS;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic            r_ar_valid;
    logic [AR_W:0]   r_ar_bits;
    logic            r_rr;
    logic [CW-1:0]   r_cnt [2];

    logic            w_free;
    logic [1:0]      w_elig;
    logic [1:0]      w_grant;
    logic [1:0]      w_ret;
    logic            w_win;
    logic            w_idx;
    logic            w_r_hs;
    logic [AR_W-1:0] w_sel;

    assign w_free    = !r_ar_valid || bus.s_ar_ready;
    assign w_elig[0] = bus.m_ar_valid[0] && (r_cnt[0] < MAX_C);
    assign w_elig[1] = bus.m_ar_valid[1] && (r_cnt[1] < MAX_C);

    // Priority master first; the other one only if the favoured one cannot go.
    always_comb begin
        w_grant = 2'b00;
        if (!reset && w_free) begin
            if (w_elig[r_rr])
                w_grant[r_rr] = 1'b1;
            else if (w_elig[!r_rr])
                w_grant[!r_rr] = 1'b1;
        end
    end

    assign w_win = w_grant[1];
    assign w_sel = w_win ? bus.m_ar_bits[2*AR_W-1:AR_W]
                         : bus.m_ar_bits[AR_W-1:0];

    assign bus.m_ar_ready = w_grant;
    assign bus.s_ar_valid = r_ar_valid;
    assign bus.s_ar_bits  = r_ar_bits;

    assign w_idx = bus.s_r_id[ID_BITS];

    assign bus.m_r_valid = (reset || !bus.s_r_valid) ? 2'b00
                         : (w_idx ? 2'b10 : 2'b01);
    assign bus.s_r_ready = !reset && bus.m_r_ready[w_idx];
    assign bus.m_r_data  = bus.s_r_data;
    assign bus.m_r_id    = bus.s_r_id[ID_BITS-1:0];
    assign bus.m_r_resp  = bus.s_r_resp;
    assign bus.m_r_last  = bus.s_r_last;

    assign w_r_hs   = bus.s_r_valid && bus.s_r_ready && bus.s_r_last;
    assign w_ret[0] = w_r_hs && !w_idx;
    assign w_ret[1] = w_r_hs && w_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ar_valid <= 1'b0;
            r_rr       <= 1'b0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            if (|w_grant) begin
                r_ar_valid <= 1'b1;
                r_ar_bits  <= {w_sel[AR_W-1:ID_BITS], w_win,
                               w_sel[ID_BITS-1:0]};
                r_rr       <= !w_win;
            end else if (w_free) begin
                r_ar_valid <= 1'b0;
            end
            // A retire with nothing outstanding is ignored rather than wrapping.
            for (int i = 0; i < 2; i++) begin
                case ({w_grant[i], w_ret[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomised and directed bench for axi_read_arbiter with an in-bench
// transaction-level model of arbitration, throttling and R routing.
module tb_axi_read_arbiter;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 64;
    localparam int ID_BITS   = 4;
    localparam int MAXO      = 4;
    localparam int AR_W      = ADDR_BITS + 8 + 3 + ID_BITS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_read_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
                          .ID_BITS(ID_BITS)) bus ();

    axi_read_arbiter #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
                       .ID_BITS(ID_BITS), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int compared = 0;
    int mismatched = 0;

    // Model state: slot contents, priority owner, unretired bursts per master.
    bit            mv;
    logic [AR_W:0] mbits;
    int            mrr;
    int            mcnt [2];
    bit            known = 0;
    int            win;
    bit            free_c;
    bit            exp_srr;

    // DRAM side: bursts accepted on the slave AR channel, served in order.
    typedef struct { logic [4:0] id; int len; } burst_t;
    burst_t dq[$];
    int     beat = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] a,
                                              input logic [7:0] l,
                                              input logic [2:0] s,
                                              input logic [3:0] id);
        return {a, l, s, id};
    endfunction

    task automatic settle();
        bit e [2];
        int pri;
        logic idx;
        logic [1:0] er;
        logic [1:0] ev;
        #1;
        free_c = !mv || bus.s_ar_ready;
        e[0] = bus.m_ar_valid[0] && (mcnt[0] < MAXO);
        e[1] = bus.m_ar_valid[1] && (mcnt[1] < MAXO);
        win = -1;
        if (!reset && free_c) begin
            pri = mrr;
            if (e[pri]) win = pri;
            else if (e[1-pri]) win = 1 - pri;
        end
        er = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
        chk("m_ar_ready", bus.m_ar_ready, er);
        idx = bus.s_r_id[ID_BITS];
        ev = (reset || !bus.s_r_valid) ? 2'b00 : (idx ? 2'b10 : 2'b01);
        chk("m_r_valid", bus.m_r_valid, ev);
        exp_srr = !reset && bus.m_r_ready[idx];
        chk("s_r_ready", bus.s_r_ready, exp_srr);
        if (bus.s_r_valid)
            chk("r_bcast", {bus.m_r_data, bus.m_r_id, bus.m_r_resp, bus.m_r_last},
                {bus.s_r_data, bus.s_r_id[ID_BITS-1:0], bus.s_r_resp, bus.s_r_last});
        if (known) begin
            chk("s_ar_valid", bus.s_ar_valid, mv);
            if (mv) chk("s_ar_bits", bus.s_ar_bits, mbits);
        end
    endtask

    task automatic advance();
        logic [AR_W-1:0] sel;
        logic w1;
        int idx;
        if (reset) begin
            mv = 0; mrr = 0; mcnt[0] = 0; mcnt[1] = 0;
            dq.delete(); beat = 0; known = 1;
        end else begin
            if (mv && bus.s_ar_ready)
                dq.push_back('{mbits[4:0], int'(mbits[15:8])});
            if (win >= 0) begin
                sel = bus.m_ar_bits[win*AR_W +: AR_W];
                w1 = (win == 1);
                mbits = {sel[AR_W-1:ID_BITS], w1, sel[ID_BITS-1:0]};
                mv = 1; mrr = 1 - win; mcnt[win]++;
            end else if (free_c) begin
                mv = 0;
            end
            if (bus.s_r_valid && exp_srr) begin
                beat++;
                if (bus.s_r_last) begin
                    idx = int'(bus.s_r_id[ID_BITS]);
                    if (mcnt[idx] > 0) mcnt[idx]--;
                    if (dq.size() > 0) void'(dq.pop_front());
                    beat = 0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        bus.s_r_valid = 1'b0;
    endtask

    task automatic drive_r(input int pct);
        bus.s_r_data = {$urandom, $urandom};
        bus.s_r_resp = 2'($urandom);
        if (dq.size() > 0 && $urandom_range(99) < pct) begin
            bus.s_r_valid = 1'b1;
            bus.s_r_id    = dq[0].id;
            bus.s_r_last  = (beat == dq[0].len);
        end else begin
            bus.s_r_valid = 1'b0;
            bus.s_r_id    = 5'($urandom);
            bus.s_r_last  = 1'($urandom);
        end
    endtask

    function automatic logic [AR_W-1:0] rand_ar();
        return mk_ar($urandom, 8'($urandom_range(3)), 3'($urandom), 4'($urandom));
    endfunction

    initial begin
        logic [1:0] seq [4];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        bus.m_ar_valid = 2'b11;
        bus.m_ar_bits  = {rand_ar(), rand_ar()};
        bus.m_r_ready  = 2'b11;
        bus.s_ar_ready = 1'b1;
        bus.s_r_valid  = 1'b1;
        bus.s_r_data   = '0;
        bus.s_r_id     = 5'h10;
        bus.s_r_resp   = 2'b00;
        bus.s_r_last   = 1'b1;

        // Reset held three cycles with every valid high
        reset = 1'b1;
        tick(); tick();
        settle();
        chk("rst_m_ar_ready", bus.m_ar_ready, 2'b00);
        chk("rst_m_r_valid", bus.m_r_valid, 2'b00);
        chk("rst_s_r_ready", bus.s_r_ready, 1'b0);
        advance();
        reset = 1'b0;
        bus.s_r_valid = 1'b0;
        settle();
        chk("rst_s_ar_valid", bus.s_ar_valid, 1'b0);
        chk("first_grant_m0", bus.m_ar_ready, 2'b01);
        advance();

        // Single master burst
        do_reset(1);
        bus.m_ar_valid = 2'b01;
        bus.m_ar_bits  = {rand_ar(), mk_ar(32'h1000, 8'd3, 3'd3, 4'd5)};
        settle(); chk("single_grant", bus.m_ar_ready, 2'b01); advance();
        bus.m_ar_valid = 2'b00;
        settle();
        chk("single_s_ar_valid", bus.s_ar_valid, 1'b1);
        chk("single_s_ar_bits", bus.s_ar_bits,
            {32'h1000, 8'd3, 3'd3, 5'b00101});
        advance();
        bus.m_r_ready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            bus.s_r_valid = 1'b1; bus.s_r_id = 5'h05;
            bus.s_r_last = (b == 3); bus.s_r_data = 64'(b);
            settle();
            chk("single_r_valid", bus.m_r_valid, 2'b01);
            chk("single_r_last", bus.m_r_last, (b == 3));
            advance();
        end
        bus.s_r_valid = 1'b0;

        // Fairness
        do_reset(1);
        bus.m_ar_valid = 2'b11;
        bus.m_ar_bits  = {mk_ar(32'h2000, 8'd0, 3'd3, 4'd3),
                          mk_ar(32'h3000, 8'd0, 3'd3, 4'd1)};
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("fair_grant", bus.m_ar_ready, seq[k]);
            if (k == 2) chk("fair_m1_id", bus.s_ar_bits[4:0], 5'h13);
            advance();
        end

        // Throttle at MAX outstanding
        do_reset(1);
        bus.m_ar_valid = 2'b01;
        bus.m_ar_bits  = {mk_ar(32'h4000, 8'd0, 3'd2, 4'd6),
                          mk_ar(32'h5000, 8'd0, 3'd2, 4'd2)};
        repeat (4) begin
            settle(); chk("thr_m0", bus.m_ar_ready, 2'b01); advance();
        end
        bus.m_ar_valid = 2'b11;
        settle(); chk("thr_blocked", bus.m_ar_ready, 2'b10); advance();
        bus.m_r_ready = 2'b11;
        bus.s_r_valid = 1'b1; bus.s_r_id = 5'h02; bus.s_r_last = 1'b1;
        settle();
        chk("thr_still_blocked", bus.m_ar_ready, 2'b10);
        chk("thr_retire_ready", bus.s_r_ready, 1'b1);
        advance();
        bus.s_r_valid = 1'b0;
        settle(); chk("thr_reenabled", bus.m_ar_ready, 2'b01); advance();

        // Backpressure, then same-cycle grant and retire on m0
        do_reset(1);
        bus.m_ar_valid = 2'b01;
        bus.m_ar_bits  = {rand_ar(), mk_ar(32'hABCD0000, 8'd1, 3'd2, 4'd7)};
        bus.s_ar_ready = 1'b0;
        settle(); chk("bp_grant", bus.m_ar_ready, 2'b01); advance();
        bus.m_ar_valid = 2'b11;
        bus.m_ar_bits  = {rand_ar(), rand_ar()};
        repeat (3) begin
            settle();
            chk("bp_ready_low", bus.m_ar_ready, 2'b00);
            chk("bp_bits_stable", bus.s_ar_bits,
                {32'hABCD0000, 8'd1, 3'd2, 5'h07});
            advance();
        end
        bus.m_ar_valid = 2'b00;
        bus.s_ar_ready = 1'b1;
        tick();
        bus.m_r_ready = 2'b01;
        bus.s_r_valid = 1'b1; bus.s_r_id = 5'h07; bus.s_r_last = 1'b0;
        tick();
        bus.s_r_last = 1'b1;
        bus.m_ar_valid = 2'b01;
        settle();
        chk("sim_grant", bus.m_ar_ready, 2'b01);
        chk("sim_retire", bus.s_r_ready, 1'b1);
        advance();
        bus.s_r_valid = 1'b0;
        bus.m_ar_valid = 2'b00;
        tick();

        // m1 R stall, then reset in the middle of the burst
        do_reset(1);
        bus.m_ar_valid = 2'b10;
        bus.m_ar_bits  = {mk_ar(32'h6000, 8'd3, 3'd3, 4'd9), rand_ar()};
        tick();
        bus.m_ar_valid = 2'b00;
        tick();
        bus.s_r_valid = 1'b1; bus.s_r_id = 5'h19; bus.s_r_last = 1'b0;
        bus.m_r_ready = 2'b01;
        repeat (2) begin
            settle();
            chk("stall_s_r_ready", bus.s_r_ready, 1'b0);
            chk("stall_m_r_valid", bus.m_r_valid, 2'b10);
            advance();
        end
        bus.m_r_ready = 2'b10;
        bus.m_ar_valid = 2'b01;
        bus.s_ar_ready = 1'b0;
        tick();
        bus.m_ar_valid = 2'b00;
        reset = 1'b1;
        settle();
        chk("midrst_m_r_valid", bus.m_r_valid, 2'b00);
        chk("midrst_s_r_ready", bus.s_r_ready, 1'b0);
        advance();
        reset = 1'b0;
        bus.s_r_valid = 1'b0;
        settle(); chk("midrst_s_ar_valid", bus.s_ar_valid, 1'b0); advance();

        // Randomised traffic in three phases of differing R pressure
        do_reset(2);
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(999) == 0) reset = 1'b1;
                else reset = 1'b0;
                bus.m_ar_valid = 2'($urandom);
                bus.m_ar_bits  = {rand_ar(), rand_ar()};
                bus.s_ar_ready = ($urandom_range(99) < 70);
                bus.m_r_ready  = {1'($urandom_range(99) < 80),
                                  1'($urandom_range(99) < 80)};
                drive_r(ph == 0 ? 20 : (ph == 1 ? 60 : 95));
                tick();
            end
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
